text_console_ctrl: RTL
======================

Name: text_console_ctrl

Overview:
Sequences writes into the text-mode framebuffer of the 1280x720 character display. The grid is 160 columns x 45 rows; each cell word is {fg[11:0], bg[11:0], char[7:0]}.
Consumes a valid/ready byte stream, maintains the cursor, interprets control codes and writes cells. Scrolls by advancing the display's 6-bit vertical row offset and blanking the row that enters at the bottom.
Sits in the write-clock domain and drives the display's write_addr/write_value/write_enable/v_offset inputs.

Parameters:
COLS, 160, text columns
ROWS, 45, text rows; v_offset wraps modulo ROWS
CLEAR_WORD, 32'hFFF0_0020, cell word used for blanking (white on black, space)

Ports:
clk  in  1  write clock; same clock as the display write port
rst_n  in  1  asynchronous, active-low reset
in_data  in  8  character or control code
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted when in_valid & in_ready at posedge clk
fg_color  in  12  foreground colour, sampled with each accepted printable byte
bg_color  in  12  background colour, sampled with each accepted printable byte
wr_addr  out  13  framebuffer cell address
wr_data  out  32  framebuffer cell word
wr_en  out  1  framebuffer write strobe
v_offset  out  6  physical row displayed at logical row 0
cur_col  out  8  cursor column, 0..COLS-1
cur_row  out  6  cursor logical row, 0..ROWS-1

Behaviour:
- Reset values: state IDLE, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, v_offset=0, cur_col=0, cur_row=0. Reset does not clear framebuffer contents. Reset asserted mid-clear aborts the clear immediately and wr_en drops asynchronously.
- Address mapping: phys_row = (cur_row + v_offset) mod ROWS, computed by one conditional subtract.
  - addr = COLS*phys_row + col, implemented as shift-add ((r<<7)+(r<<5)). All outputs are registered.
- States: IDLE, CLR_ROW, CLR_ALL. in_ready = (state==IDLE).
- IDLE, accepted byte:
  - Printable (0x20..0xFF, plus 0x00..0x07): next cycle wr_en=1, wr_addr=cell address, wr_data={fg_color,bg_color,in_data}. Then cur_col++.
  - If cur_col was COLS-1, the printable byte performs an implicit newline.
  - Sustained throughput is 1 byte/cycle.
- Control codes (no write unless stated):
  - 0x0A newline: cur_col=0, then advance row.
  - 0x0D carriage return: cur_col=0.
  - 0x08 backspace: cur_col-- if >0; no-op at col 0.
  - 0x09 tab: cur_col = next multiple of 8; reaching COLS performs a newline.
  - 0x0C form feed: enter CLR_ALL.
- Advance row:
  - If cur_row<ROWS-1: cur_row++ in the same cycle; stay IDLE.
  - Else: enter CLR_ROW with k=0; cur_row stays ROWS-1.
- CLR_ROW: 160 consecutive cycles with wr_en=1, wr_addr=COLS*v_offset+k, wr_data=CLEAR_WORD, k=0..159.
  - The cycle after the last write: v_offset = (v_offset==ROWS-1) ? 0 : v_offset+1; return to IDLE.
  - v_offset changes only at this point, holding each value ≥160 cycles. This satisfies the display's 4-sample stability filter.
- CLR_ALL: writes addr 0..COLS*ROWS-1 (7199) with CLEAR_WORD, one per cycle (7200 cycles).
  - Then v_offset=0, cur_row=0, cur_col=0; return to IDLE.
- wr_en is low in every cycle not described above. No back-pressure exists on the write port.
- Width rules: the cursor column counter is 8 bits and never exceeds COLS-1. The clear counter is 13 bits. Address arithmetic is 13 bits with no overflow (max 7199).

Decomposition:
- Shared package text_console_pkg:
  - COLS, ROWS, CELLS=7200
  - control codes (NL, CR, BS, TAB, FF)
  - state enum
  - function cell_addr(row, col, offset) implementing the mapping above
- Single module; no sub-module warranted.

Test Plan:
1. Release reset, send 0x41 with fg=F00, bg=00F -> one cycle later wr_en=1, wr_addr=0, wr_data=32'hF0000F41; cur_col=1; in_ready stays 1.
2. Send 160 consecutive 0x41 -> wr_addr 0..159 on back-to-back cycles; afterwards cur_row=1, cur_col=0; next byte writes addr 160.
3. Send 44 x 0x0A, then one more 0x0A -> cur_row=44; in_ready low 160 cycles; writes addr 0..159 with 32'hFFF00020; then v_offset=1. Next 0x42 writes addr 0.
4. Force 44 scrolls (v_offset=44), then one more scroll -> clear writes 7040..7199; v_offset wraps to 0.
5. At cur_col=0 send 0x08 -> no write, cur_col=0. Send 0x09 at cur_col=3 -> cur_col=8, no write. Send 0x0C -> 7200 writes 0..7199, then cursor (0,0), v_offset=0.
6. Assert rst_n low at clear cycle 3000 of CLR_ALL -> wr_en=0 immediately. After release: in_ready=1, v_offset=0, cursor (0,0), no further writes until input arrives.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared constants, control codes, FSM state type and cell address mapping
// for the text console write sequencer.
package text_console_pkg;

    localparam int COLS  = 160;
    localparam int ROWS  = 45;
    localparam int CELLS = COLS * ROWS;

    localparam logic [31:0] CLEAR_WORD = 32'hFFF0_0020;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_NL  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR_ROW,
        ST_CLR_ALL
    } state_t;

    // row + offset never exceeds 2*ROWS-2, so one conditional subtract wraps it;
    // COLS*r is formed as (r<<7)+(r<<5).
    function automatic logic [12:0] cell_addr(input logic [5:0] row,
                                              input logic [7:0] col,
                                              input logic [5:0] offset);
        logic [6:0] sum;
        logic [5:0] r;
        sum = {1'b0, row} + {1'b0, offset};
        if (sum >= 7'(ROWS))
            sum = sum - 7'(ROWS);
        r = sum[5:0];
        return {r, 7'b0} + {2'b00, r, 5'b0} + {5'b0, col};
    endfunction

endpackage

// File: rtl/text_console_ctrl.sv
// Text console write sequencer: consumes a byte stream, tracks the cursor,
// writes framebuffer cells and scrolls by advancing the display row offset.
//
// state      | meaning
// ST_IDLE    | accepting bytes, one per cycle
// ST_CLR_ROW | blanking the physical row that becomes the new bottom line
// ST_CLR_ALL | blanking the whole framebuffer after a form feed
module text_console_ctrl
    import text_console_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] fg_color,
    input  logic [11:0] bg_color,
    output logic [12:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_en,
    output logic [5:0]  v_offset,
    output logic [7:0]  cur_col,
    output logic [5:0]  cur_row
);

    localparam logic [7:0]  COL_MAX   = 8'(COLS - 1);
    localparam logic [7:0]  COL_END   = 8'(COLS);
    localparam logic [5:0]  ROW_MAX   = 6'(ROWS - 1);
    localparam logic [12:0] ROW_WORDS = 13'(COLS);
    localparam logic [12:0] CELL_LAST = 13'(CELLS - 1);

    state_t      state, state_nxt;
    logic        accept, is_print, nl_req, scroll;
    logic [7:0]  tab_col;
    logic [12:0] row_base;
    logic [12:0] clr_cnt, clr_cnt_nxt, clr_addr, clr_addr_nxt;
    logic        wr_en_nxt;
    logic [12:0] wr_addr_nxt;
    logic [31:0] wr_data_nxt;
    logic [5:0]  v_offset_nxt, cur_row_nxt;
    logic [7:0]  cur_col_nxt;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign is_print = (in_data >= 8'h20) || (in_data <= 8'h07);
    assign tab_col  = {cur_col[7:3] + 5'd1, 3'b000};
    assign row_base = cell_addr(6'd0, 8'd0, v_offset);
    assign nl_req   = accept && ((is_print && cur_col == COL_MAX) ||
                                 (in_data == CH_NL) ||
                                 (in_data == CH_TAB && tab_col >= COL_END));
    assign scroll   = nl_req && (cur_row == ROW_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && !is_print && in_data == CH_FF)
                    state_nxt = ST_CLR_ALL;
                else if (scroll)
                    state_nxt = ST_CLR_ROW;
            end
            ST_CLR_ROW, ST_CLR_ALL: begin
                if (clr_cnt == '0)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // clr_cnt counts writes still owed; a newline-triggered clear issues its
    // first write on entry, a wrap after a printable leaves all 160 pending.
    always_comb begin
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        clr_cnt_nxt  = clr_cnt;
        clr_addr_nxt = clr_addr;
        v_offset_nxt = v_offset;
        cur_col_nxt  = cur_col;
        cur_row_nxt  = cur_row;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = cell_addr(cur_row, cur_col, v_offset);
                        wr_data_nxt = {fg_color, bg_color, in_data};
                        cur_col_nxt = cur_col + 8'd1;
                    end else begin
                        case (in_data)
                            CH_CR:  cur_col_nxt = 8'd0;
                            CH_BS:  if (cur_col != 8'd0) cur_col_nxt = cur_col - 8'd1;
                            CH_TAB: cur_col_nxt = tab_col;
                            CH_FF: begin
                                wr_en_nxt    = 1'b1;
                                wr_addr_nxt  = 13'd0;
                                wr_data_nxt  = CLEAR_WORD;
                                clr_addr_nxt = 13'd1;
                                clr_cnt_nxt  = CELL_LAST;
                            end
                            default: ;
                        endcase
                    end
                    if (nl_req) begin
                        cur_col_nxt = 8'd0;
                        if (!scroll) begin
                            cur_row_nxt = cur_row + 6'd1;
                        end else if (is_print) begin
                            clr_addr_nxt = row_base;
                            clr_cnt_nxt  = ROW_WORDS;
                        end else begin
                            wr_en_nxt    = 1'b1;
                            wr_addr_nxt  = row_base;
                            wr_data_nxt  = CLEAR_WORD;
                            clr_addr_nxt = row_base + 13'd1;
                            clr_cnt_nxt  = ROW_WORDS - 13'd1;
                        end
                    end
                end
            end
            ST_CLR_ROW, ST_CLR_ALL: begin
                if (clr_cnt != '0) begin
                    wr_en_nxt    = 1'b1;
                    wr_addr_nxt  = clr_addr;
                    wr_data_nxt  = CLEAR_WORD;
                    clr_addr_nxt = clr_addr + 13'd1;
                    clr_cnt_nxt  = clr_cnt - 13'd1;
                end else if (state == ST_CLR_ROW) begin
                    v_offset_nxt = (v_offset == ROW_MAX) ? 6'd0 : v_offset + 6'd1;
                end else begin
                    v_offset_nxt = 6'd0;
                    cur_row_nxt  = 6'd0;
                    cur_col_nxt  = 8'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            clr_cnt  <= '0;
            clr_addr <= '0;
            v_offset <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
        end else begin
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            clr_cnt  <= clr_cnt_nxt;
            clr_addr <= clr_addr_nxt;
            v_offset <= v_offset_nxt;
            cur_col  <= cur_col_nxt;
            cur_row  <= cur_row_nxt;
        end
    end

endmodule
